// File: rtl/aes_key_sched_pkg.sv
// Shared AES constants, FSM encoding and byte-level helpers for key expansion.
package aes_key_sched_pkg;

  localparam int NUM_RNDS = 10;
  localparam int KEY_W    = 128;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254) followed by the affine map,
  // avoiding a hand-typed 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant byte for rounds 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_gen.sv
// One AES-128 key-expansion round: derives round key N from round key N-1.
module aes_key_gen
  import aes_key_sched_pkg::*;
(
  input  logic [KEY_W-1:0] pre_rnd_key,
  input  logic [3:0]       round_num,
  input  logic             i_en_key_gen,
  output logic [KEY_W-1:0] rnd_key
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  // Word recurrence: RotWord, SubWord, Rcon on w3, then chained XORs.
  always_comb begin
    w0   = pre_rnd_key[127:96];
    w1   = pre_rnd_key[95:64];
    w2   = pre_rnd_key[63:32];
    w3   = pre_rnd_key[31:0];
    temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_num), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    rnd_key = i_en_key_gen ? {n0, n1, n2, n3} : '0;
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key scheduler: expands one cipher key into 11 stored round keys,
// one round per cycle, with a registered random-access read port.
module aes_key_sched
  import aes_key_sched_pkg::*;
#(
  parameter int NUM_RNDS = aes_key_sched_pkg::NUM_RNDS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_key_vld,
  input  logic [KEY_W-1:0] i_key,
  output logic             o_key_rdy,
  output logic             o_busy,
  output logic             o_sched_vld,
  input  logic [3:0]       i_rd_idx,
  output logic [KEY_W-1:0] o_rd_key
);

  localparam int         NUM_SLOTS = NUM_RNDS + 1;
  localparam logic [3:0] LAST_RND  = 4'(NUM_RNDS);

  state_t           state, next_state;
  logic [3:0]       cnt;
  logic [3:0]       prev_idx;
  logic             load, step;
  logic             sched_vld;
  logic [KEY_W-1:0] rd_key;
  logic [KEY_W-1:0] prev_key, next_key;
  logic [KEY_W-1:0] slot [NUM_SLOTS];

  assign o_key_rdy   = (state != EXPAND);
  assign o_busy      = (state == EXPAND);
  assign o_sched_vld = sched_vld;
  assign o_rd_key    = rd_key;

  assign load     = i_key_vld & o_key_rdy;
  assign step     = (state == EXPAND);
  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign prev_key = slot[prev_idx];

  aes_key_gen u_key_gen (
    .pre_rnd_key  (prev_key),
    .round_num    (cnt),
    .i_en_key_gen (1'b1),
    .rnd_key      (next_key)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: a handshake starts expansion, the last round ends it.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    next_state = state;
    case (state)
      IDLE, DONE: if (load) next_state = EXPAND;
      EXPAND:     if (cnt == LAST_RND) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // Round counter, schedule-valid flag and registered read port.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt       <= 4'd0;
      sched_vld <= 1'b0;
      rd_key    <= '0;
    end else begin
      if (load) begin
        cnt       <= 4'd1;
        sched_vld <= 1'b0;
      end else if (step) begin
        if (cnt == LAST_RND) sched_vld <= 1'b1;
        else                 cnt       <= cnt + 4'd1;
      end
      rd_key <= (i_rd_idx <= LAST_RND) ? slot[i_rd_idx] : '0;
    end
  end

  // Round-key storage: slot 0 takes the cipher key, slot[cnt] each expand cycle.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; consumers qualify reads with
    // o_sched_vld, so clearing the array would only cost reset fan-out.
    if (i_rst_n) begin
      if (load)      slot[0]   <= i_key;
      else if (step) slot[cnt] <= next_key;
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed self-checking bench for aes_key_sched using FIPS-197 key vectors.
module tb_aes_key_sched;

  logic         clk;
  logic         rst_n;
  logic         key_vld;
  logic [127:0] key;
  logic         key_rdy;
  logic         busy;
  logic         sched_vld;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int total = 0;
  int bad   = 0;

  logic [127:0] key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] key_b = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] b_rk1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  logic [127:0] b_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] a_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_vld   (key_vld),
    .i_key       (key),
    .o_key_rdy   (key_rdy),
    .o_busy      (busy),
    .o_sched_vld (sched_vld),
    .i_rd_idx    (rd_idx),
    .o_rd_key    (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    key_vld = 1'b0;
    key     = '0;
    rd_idx  = 4'd0;
    repeat (2) tick();
    check("rst_rdy", key_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_vld", sched_vld, 0);
    check("rst_rdkey", rd_key, 0);
    rst_n = 1'b1;

    // FIPS key; a second key offered at T+4 must be ignored.
    key = key_a; key_vld = 1'b1;
    tick();
    key_vld = 1'b0; key = '0;
    check("a_busy", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("a_rdy_c%0d", k), key_rdy, 0);
      check($sformatf("a_vld_c%0d", k), sched_vld, 0);
      if (k == 4) begin key_vld = 1'b1; key = key_b; end
      else        begin key_vld = 1'b0; key = '0; end
      tick();
    end
    check("a_vld_done", sched_vld, 1);
    check("a_busy_done", busy, 0);
    check("a_rdy_done", key_rdy, 1);

    // Sweep every read index in DONE.
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      check($sformatf("sweep_%0d", i), rd_key, (i <= 10) ? a_rk[i] : 128'h0);
    end
    check("sweep_vld", sched_vld, 1);

    // Restart from DONE; slot 1 read at its own write edge returns old data.
    rd_idx = 4'd1; key = key_b; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    check("b_vld_drop", sched_vld, 0);
    check("b_busy", busy, 1);
    tick();
    check("b_rd_stale", rd_key, a_rk[1]);
    tick();
    check("b_rd_new", rd_key, b_rk1);
    repeat (8) tick();
    check("b_vld_done", sched_vld, 1);
    rd_idx = 4'd10;
    tick();
    check("b_rk10", rd_key, b_rk10);

    // Reset in the middle of an expansion.
    key = key_a; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", sched_vld, 0);
    check("mid_rst_rdkey", rd_key, 0);
    rst_n = 1'b1;
    check("mid_rst_rdy", key_rdy, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("abort_vld_%0d", k), sched_vld, 0);
    end
    key = key_b; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    repeat (10) tick();
    check("fresh_vld", sched_vld, 1);
    rd_idx = 4'd10;
    tick();
    check("fresh_rk10", rd_key, b_rk10);

    // Back-to-back handshakes with key_vld held high: 11-cycle period.
    key = key_a; key_vld = 1'b1;
    tick();
    for (int n = 1; n <= 22; n++) begin
      tick();
      check($sformatf("b2b_vld_%0d", n), sched_vld, (n == 10 || n == 21) ? 1 : 0);
    end
    key_vld = 1'b0;
    repeat (10) tick();
    check("b2b_final_vld", sched_vld, 1);
    rd_idx = 4'd10;
    tick();
    check("b2b_rk10", rd_key, a_rk[10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
